// File: rtl/video_pattern_scheduler_if.sv
// Interface bundling the video-side signals of video_pattern_scheduler.
// The master side (timing generator, PLL, host controls) drives sync, lock and
// requests; the slave side (the scheduler) drives pattern select, blanking and
// frame information. The freeze control exists only when PATTERN_FREEZE_EN is
// defined.
interface video_pattern_scheduler_if #(
   parameter int PSEL_W = 3
);
   logic              clk_locked;
   logic              video_vs;
   logic              auto_en;
   logic              next_req;
   logic              next_ack;
   logic [PSEL_W-1:0] pattern_sel;
   logic              blank;
   logic              frame_start;
   logic [15:0]       frame_cnt;
`ifdef PATTERN_FREEZE_EN
   logic              freeze;

   modport master (
      output clk_locked, video_vs, auto_en, next_req, freeze,
      input  next_ack, pattern_sel, blank, frame_start, frame_cnt
   );

   modport slave (
      input  clk_locked, video_vs, auto_en, next_req, freeze,
      output next_ack, pattern_sel, blank, frame_start, frame_cnt
   );
`else
   modport master (
      output clk_locked, video_vs, auto_en, next_req,
      input  next_ack, pattern_sel, blank, frame_start, frame_cnt
   );

   modport slave (
      input  clk_locked, video_vs, auto_en, next_req,
      output next_ack, pattern_sel, blank, frame_start, frame_cnt
   );
`endif
endinterface

// File: rtl/video_pattern_scheduler.sv
// Frame-synchronous test-pattern scheduler on the pixel clock.
// Detects frame starts from video_vs, holds the output blanked until the PLL is
// locked and a few startup frames have passed, then steps through the test
// patterns either on a dwell timer (auto_en) or on request (next_req/next_ack).
// Every pattern, blank and ack change lands in the frame_start cycle so no
// frame is torn; only loss of lock acts immediately.
// Optional feature: define PATTERN_FREEZE_EN to add a freeze input that halts
// auto advance and holds the dwell timer while manual requests still work.
module video_pattern_scheduler #(
   parameter int NUM_PATTERNS       = 8,
   parameter int PSEL_W             = 3,
   parameter int FRAMES_PER_PATTERN = 120,
   parameter int STARTUP_FRAMES     = 2,
   parameter bit VS_POL             = 1'b1
) (
   input  logic                      pixel_clk,
   input  logic                      rst_n,
   video_pattern_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STARTUP   = 2'd1,
      RUN       = 2'd2
   } state_t;

   localparam int DWELL_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
   localparam int START_W = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;
   localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(FRAMES_PER_PATTERN - 1);
   localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_FRAMES - 1);
   localparam logic [PSEL_W-1:0]  PSEL_LAST  = PSEL_W'(NUM_PATTERNS - 1);

   state_t              state_q, state_d;
   logic                vsDly_q;
   logic                pending_q, pending_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [START_W-1:0]  startCnt_q, startCnt_d;
   logic [PSEL_W-1:0]   patternSel_q, patternSel_d;
   logic                blank_q, blank_d;
   logic                nextAck_q, nextAck_d;
   logic                frameStart_q, frameStart_d;
   logic [15:0]         frameCnt_q, frameCnt_d;

   logic                vsAct;
   logic                fs;
   logic                freezeActive;
   logic                autoAdv;
   logic                advance;

   // Normalise the sync polarity so the rest of the logic sees active-high.
   assign vsAct = ~(bus.video_vs ^ VS_POL);
   assign fs    = vsAct & ~vsDly_q;

`ifdef PATTERN_FREEZE_EN
   assign freezeActive = bus.freeze;
`else
   assign freezeActive = 1'b0;
`endif

   // State and output registers; reset puts the display blanked on pattern 0.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_LOCK;
         vsDly_q      <= 1'b0;
         pending_q    <= 1'b0;
         dwell_q      <= '0;
         startCnt_q   <= '0;
         patternSel_q <= '0;
         blank_q      <= 1'b1;
         nextAck_q    <= 1'b0;
         frameStart_q <= 1'b0;
         frameCnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         vsDly_q      <= vsAct;
         pending_q    <= pending_d;
         dwell_q      <= dwell_d;
         startCnt_q   <= startCnt_d;
         patternSel_q <= patternSel_d;
         blank_q      <= blank_d;
         nextAck_q    <= nextAck_d;
         frameStart_q <= frameStart_d;
         frameCnt_q   <= frameCnt_d;
      end
   end

   // Next-state logic: lock loss overrides everything, otherwise frame edges
   // drive startup counting and pattern advance. A request arriving in the
   // same cycle as the servicing frame edge is re-latched after the clear so
   // it stays pending for the following frame.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      dwell_d      = dwell_q;
      startCnt_d   = startCnt_q;
      patternSel_d = patternSel_q;
      blank_d      = blank_q;
      nextAck_d    = 1'b0;
      frameStart_d = 1'b0;
      frameCnt_d   = frameCnt_q;
      autoAdv      = 1'b0;
      advance      = 1'b0;

      if (!bus.clk_locked) begin
         state_d      = WAIT_LOCK;
         pending_d    = 1'b0;
         dwell_d      = '0;
         startCnt_d   = '0;
         patternSel_d = '0;
         blank_d      = 1'b1;
         frameCnt_d   = '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               pending_d    = 1'b0;
               dwell_d      = '0;
               startCnt_d   = '0;
               patternSel_d = '0;
               blank_d      = 1'b1;
               frameCnt_d   = '0;
               state_d      = STARTUP;
            end
            STARTUP: begin
               if (bus.next_req) begin
                  pending_d = 1'b1;
               end
               if (fs) begin
                  frameStart_d = 1'b1;
                  frameCnt_d   = frameCnt_q + 16'd1;
                  if (startCnt_q == START_LAST) begin
                     state_d    = RUN;
                     blank_d    = 1'b0;
                     startCnt_d = '0;
                  end else begin
                     startCnt_d = startCnt_q + 1'b1;
                  end
               end
            end
            RUN: begin
               if (fs) begin
                  frameStart_d = 1'b1;
                  frameCnt_d   = frameCnt_q + 16'd1;
                  autoAdv      = bus.auto_en & ~freezeActive & (dwell_q == DWELL_MAX);
                  advance      = pending_q | autoAdv;
                  if (advance) begin
                     patternSel_d = (patternSel_q == PSEL_LAST) ? '0 : patternSel_q + 1'b1;
                     dwell_d      = '0;
                  end else if ((dwell_q != DWELL_MAX) && !freezeActive) begin
                     dwell_d = dwell_q + 1'b1;
                  end
                  if (pending_q) begin
                     nextAck_d = 1'b1;
                     pending_d = 1'b0;
                  end
               end
               if (bus.next_req) begin
                  pending_d = 1'b1;
               end
            end
            default: begin
               state_d = WAIT_LOCK;
            end
         endcase
      end
   end

   assign bus.next_ack    = nextAck_q;
   assign bus.pattern_sel = patternSel_q;
   assign bus.blank       = blank_q;
   assign bus.frame_start = frameStart_q;
   assign bus.frame_cnt   = frameCnt_q;

endmodule
